// File: rtl/rsc_frame_encoder_if.sv
// rsc_frame_encoder_if: serial info-bit input and parallel frame output handshakes of the RSC encoder.
interface rsc_frame_encoder_if #(
  parameter int BITS            = 16,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 10
);
  logic            in_valid;
  logic            in_ready;
  logic            in_bit;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_llr [BITS_PER_SYMBOL][SYMBOLS];
  modport master (output in_valid, in_bit, out_ready, input in_ready, out_valid, out_llr);
  modport slave  (input in_valid, in_bit, out_ready, output in_ready, out_valid, out_llr);
endinterface

// File: rtl/rsc_frame_encoder.sv
// rsc_frame_encoder: rate-1/2 RSC encoder producing one terminated frame as out_llr[h][g].
// Optional ENC_BPSK_MAP_EN maps each bit to a half-precision BPSK word instead of a raw hard bit.
module rsc_frame_encoder #(
  parameter int                BITS            = 16,
  parameter int                BITS_PER_SYMBOL = 2,
  parameter int                SYMBOLS         = 10,
  parameter int                MEMORY          = 2,
  parameter logic [MEMORY:0]   FB_POLY         = 3'b111,
  parameter logic [MEMORY:0]   FF_POLY         = 3'b101
) (
  input logic                 clk,
  input logic                 rst_n,
  rsc_frame_encoder_if.slave  bus
);
  localparam int CW = $clog2(SYMBOLS + 1);
  localparam logic [1:0] LOAD = 2'd0, TAIL = 2'd1, DONE = 2'd2;
  if (BITS_PER_SYMBOL != 2) begin : g_bad_bps
    $error("rsc_frame_encoder: BITS_PER_SYMBOL must be 2");
  end
  if (SYMBOLS <= MEMORY) begin : g_bad_sym
    $error("rsc_frame_encoder: SYMBOLS must exceed MEMORY");
  end
  if (FB_POLY[MEMORY] != 1'b1) begin : g_bad_fb
    $error("rsc_frame_encoder: FB_POLY input tap must be 1");
  end
  logic [1:0]         st;
  logic [CW-1:0]      cnt;
  logic [MEMORY-1:0]  sr;
  logic [SYMBOLS-1:0] sys_q, par_q;
  logic               fb, u, a, par, step;
  logic [MEMORY:0]    ext;
  always_comb begin
    fb   = ^(sr & FB_POLY[MEMORY-1:0]);
    u    = (st == TAIL) ? fb : bus.in_bit;
    a    = u ^ fb;
    ext  = {a, sr};
    par  = ^(ext & FF_POLY);
    step = (st == TAIL) || (st == LOAD && bus.in_valid);
  end
  assign bus.in_ready  = (st == LOAD);
  assign bus.out_valid = (st == DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= LOAD;
      cnt   <= '0;
      sr    <= '0;
      sys_q <= '0;
      par_q <= '0;
    end else if (step) begin
      sys_q[cnt] <= u;
      par_q[cnt] <= par;
      sr         <= ext[MEMORY:1];
      cnt        <= cnt + CW'(1);
      if (st == LOAD && cnt == CW'(SYMBOLS - MEMORY - 1)) st <= TAIL;
      if (st == TAIL && cnt == CW'(SYMBOLS - 1)) st <= DONE;
    end else if (st == DONE && bus.out_ready) begin
      st  <= LOAD;
      cnt <= '0;
      sr  <= '0;
    end
  end
`ifdef ENC_BPSK_MAP_EN
  if (BITS < 16) begin : g_bad_bits
    $error("rsc_frame_encoder: ENC_BPSK_MAP_EN requires BITS >= 16");
  end
  // Steps never written since reset must still read as zero words, not +1.0.
  logic [SYMBOLS-1:0] wr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr <= '0;
    else if (step) wr[cnt] <= 1'b1;
  end
  for (genvar g = 0; g < SYMBOLS; g++) begin : g_map
    assign bus.out_llr[0][g] = wr[g] ? BITS'(sys_q[g] ? 16'hBC00 : 16'h3C00) : '0;
    assign bus.out_llr[1][g] = wr[g] ? BITS'(par_q[g] ? 16'hBC00 : 16'h3C00) : '0;
  end
`else
  for (genvar g = 0; g < SYMBOLS; g++) begin : g_map
    assign bus.out_llr[0][g] = BITS'(sys_q[g]);
    assign bus.out_llr[1][g] = BITS'(par_q[g]);
  end
`endif
endmodule
